// File: rtl/ixc_skid_slice.sv
// ixc_skid_slice
// Registered valid/ready pipeline slice with a two-entry skid buffer. It
// breaks the combinational ready path between producer logic and the
// per-bit assign stage while keeping one transfer per cycle.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous, active-low reset
//   R        - upstream data (WIDTH bits)
//   r_valid  - upstream data valid
//   r_ready  - slice can accept (registered)
//   L        - downstream data (registered, from main register M)
//   l_valid  - L holds a valid word (registered)
//   l_ready  - downstream accepts
//   occ      - number of words held, 0..2 (registered, equals FSM state)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The upstream side may drop r_valid without a transfer; the
// slice never samples R unless r_valid & r_ready. Once l_valid is high, L
// and l_valid hold until a downstream transfer. l_ready with l_valid low
// has no effect.

module ixc_skid_slice #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic             r_valid,
    output logic             r_ready,
    output logic [WIDTH-1:0] L,
    output logic             l_valid,
    input  logic             l_ready,
    output logic [1:0]       occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] s_q;
    logic             r_ready_q;
    logic             l_valid_q;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_m_from_r;
    logic             load_m_from_s;
    logic             load_s;

    assign in_xfer  = r_valid & r_ready_q;
    assign out_xfer = l_valid_q & l_ready;

    always_comb begin
        next_state    = state;
        load_m_from_r = 1'b0;
        load_m_from_s = 1'b0;
        load_s        = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    next_state    = ONE;
                    load_m_from_r = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m_from_r = 1'b1;
                end else if (in_xfer) begin
                    // M is stalled: park the new word behind it.
                    next_state = TWO;
                    load_s     = 1'b1;
                end else if (out_xfer) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                // r_ready is low here, so no upstream transfer can coincide.
                if (out_xfer) begin
                    next_state    = ONE;
                    load_m_from_s = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            m_q       <= '0;
            s_q       <= '0;
            r_ready_q <= 1'b0;
            l_valid_q <= 1'b0;
        end else begin
            state     <= next_state;
            // Both flags come from next state so they are true flop outputs.
            r_ready_q <= (next_state != TWO);
            l_valid_q <= (next_state != EMPTY);
            if (load_m_from_r) begin
                m_q <= R;
            end else if (load_m_from_s) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= R;
            end
        end
    end

    assign L       = m_q;
    assign l_valid = l_valid_q;
    assign r_ready = r_ready_q;
    assign occ     = state;

endmodule
